// File: rtl/prng_pkg.sv
// Shared types and widths for the PRNG sample path.
// Holds field widths and the packed sample record.
package prng_pkg;

  localparam int X_W      = 8;
  localparam int Y_W      = 8;
  localparam int STEP_W   = 16;
  localparam int SAMPLE_W = 32;

  typedef struct packed {
    logic [STEP_W-1:0] step;
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
  } prng_sample_t;

endpackage

// File: rtl/prng_sample_mem.sv
// Sample storage: DEPTH x SAMPLE_W, one write port, async read.
// Ports: clk, we/waddr/wdata write side, raddr/rdata read side.
module prng_sample_mem
  import prng_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we,
  input  logic [AW-1:0] waddr,
  input  prng_sample_t wdata,
  input  logic [AW-1:0] raddr,
  output prng_sample_t rdata
);

  prng_sample_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/prng_sample_fifo.sv
// Lossy FIFO for PRNG samples: no producer back-pressure, drops counted.
// Ports: clk/rst_n/clear, in_* push side, out_* pop side, count/flags/stats.
module prng_sample_fifo
  import prng_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [X_W-1:0]    in_x,
  input  logic [Y_W-1:0]    in_y,
  input  logic [STEP_W-1:0] in_step,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic [STEP_W-1:0] out_step,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty,
  output logic [15:0]       drop_count,
  output logic              overflow
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [15:0]   drop_q, drop_d;
  logic          ovf_q, ovf_d;

  logic push, pop, drop, we;
  prng_sample_t wdata, rdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);

  // A pop frees a slot this cycle, so a push at full is still accepted.
  assign pop  = !empty && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      drop_d   = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
      ovf_q    <= ovf_d;
    end
  end

  assign we    = push && !clear && rst_n;
  assign wdata = '{step: in_step, x: in_x, y: in_y};

  prng_sample_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign out_valid  = !empty;
  assign out_x      = rdata.x;
  assign out_y      = rdata.y;
  assign out_step   = rdata.step;
  assign count      = count_q;
  assign drop_count = drop_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_prng_sample_fifo.sv
// Directed bench for prng_sample_fifo (DEPTH=16).
// Vector table for basic traffic, hand sequences for multi-cycle corners.
module tb_prng_sample_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [7:0]  in_x, in_y, out_x, out_y;
  logic [15:0] in_step, out_step, drop_count;
  logic        out_valid, full, empty, overflow;
  logic [4:0]  count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  prng_sample_fifo #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_step    (in_step),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_step   (out_step),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .drop_count (drop_count),
    .overflow   (overflow)
  );

  typedef struct {
    logic        iv;
    logic [15:0] st;
    logic        ordy;
    logic        clr;
    int          ecnt;
    logic        evld;
    logic [15:0] estep;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic drive(input logic iv, input logic [15:0] st,
                       input logic ordy, input logic clr);
    in_valid  = iv;
    in_step   = st;
    in_x      = st[7:0];
    in_y      = {st[6:0], 1'b0};
    out_ready = ordy;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string nm, input logic [15:0] st);
    logic [7:0] ex, ey;
    ex = st[7:0];
    ey = {st[6:0], 1'b0};
    chk({nm, ".valid"}, out_valid, 1'b1);
    chk({nm, ".step"}, out_step, st);
    chk({nm, ".x"}, out_x, ex);
    chk({nm, ".y"}, out_y, ey);
  endtask

  initial begin
    logic [15:0] s;

    tbl = '{
      '{1'b1, 16'd1,  1'b1, 1'b0, 1, 1'b1, 16'd1},
      '{1'b1, 16'd2,  1'b1, 1'b0, 1, 1'b1, 16'd2},
      '{1'b1, 16'd3,  1'b1, 1'b0, 1, 1'b1, 16'd3},
      '{1'b1, 16'd4,  1'b1, 1'b0, 1, 1'b1, 16'd4},
      '{1'b1, 16'd5,  1'b1, 1'b0, 1, 1'b1, 16'd5},
      '{1'b0, 16'd0,  1'b1, 1'b0, 0, 1'b0, 16'd0},
      '{1'b0, 16'd0,  1'b1, 1'b0, 0, 1'b0, 16'd0},
      '{1'b1, 16'd10, 1'b0, 1'b0, 1, 1'b1, 16'd10},
      '{1'b1, 16'd11, 1'b0, 1'b0, 2, 1'b1, 16'd10},
      '{1'b1, 16'd12, 1'b0, 1'b0, 3, 1'b1, 16'd10},
      '{1'b0, 16'd0,  1'b0, 1'b0, 3, 1'b1, 16'd10},
      '{1'b0, 16'd0,  1'b1, 1'b0, 2, 1'b1, 16'd11},
      '{1'b0, 16'd0,  1'b1, 1'b0, 1, 1'b1, 16'd12},
      '{1'b0, 16'd0,  1'b1, 1'b0, 0, 1'b0, 16'd0}
    };

    // reset held with traffic present
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 16'd7, 1'b0, 1'b0);
    chk("rst.count", count, 0);
    chk("rst.empty", empty, 1'b1);
    chk("rst.full", full, 1'b0);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.drop", drop_count, 0);
    chk("rst.ovf", overflow, 1'b0);
    rst_n = 1'b1;

    // table: ordering, pop-while-empty, hold while stalled
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].iv, tbl[i].st, tbl[i].ordy, tbl[i].clr);
      chk($sformatf("vec%0d.count", i), count, tbl[i].ecnt);
      chk($sformatf("vec%0d.valid", i), out_valid, tbl[i].evld);
      chk($sformatf("vec%0d.empty", i), empty, !tbl[i].evld);
      if (tbl[i].evld) chk_head($sformatf("vec%0d", i), tbl[i].estep);
    end

    // overflow: 20 pushes into 16 entries
    for (int i = 1; i <= 20; i++) drive(1'b1, 16'(i), 1'b0, 1'b0);
    chk("ovf.full", full, 1'b1);
    chk("ovf.count", count, 16);
    chk("ovf.drop", drop_count, 4);
    chk("ovf.flag", overflow, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      chk_head($sformatf("ovf.drain%0d", i), 16'(i));
      drive(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("ovf.empty", empty, 1'b1);
    chk("ovf.sticky", overflow, 1'b1);
    chk("ovf.drop_hold", drop_count, 4);

    drive(1'b0, 16'd0, 1'b0, 1'b1);
    chk("clr1.drop", drop_count, 0);
    chk("clr1.ovf", overflow, 1'b0);

    // full with simultaneous push and pop
    for (int k = 0; k < 16; k++) drive(1'b1, 16'(100 + k), 1'b0, 1'b0);
    chk("fpp.full", full, 1'b1);
    for (int k = 0; k < 10; k++) begin
      chk_head($sformatf("fpp.head%0d", k), 16'(100 + k));
      drive(1'b1, 16'(116 + k), 1'b1, 1'b0);
      chk($sformatf("fpp.count%0d", k), count, 16);
    end
    chk("fpp.drop", drop_count, 0);
    chk("fpp.ovf", overflow, 1'b0);
    for (int k = 0; k < 16; k++) begin
      chk_head($sformatf("fpp.drain%0d", k), 16'(110 + k));
      drive(1'b0, 16'd0, 1'b1, 1'b0);
    end
    chk("fpp.empty", empty, 1'b1);

    // clear beats push, pop and stats
    for (int k = 0; k < 19; k++) drive(1'b1, 16'(200 + k), 1'b0, 1'b0);
    for (int k = 0; k < 9; k++) drive(1'b0, 16'd0, 1'b1, 1'b0);
    chk("clr.pre_count", count, 7);
    chk("clr.pre_drop", drop_count, 3);
    drive(1'b1, 16'd300, 1'b1, 1'b1);
    chk("clr.count", count, 0);
    chk("clr.empty", empty, 1'b1);
    chk("clr.drop", drop_count, 0);
    chk("clr.ovf", overflow, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    chk("clr.lost", count, 0);
    drive(1'b1, 16'd301, 1'b0, 1'b0);
    chk_head("clr.next", 16'd301);
    chk("clr.next_count", count, 1);

    // reset mid-stream discards contents
    drive(1'b1, 16'd302, 1'b0, 1'b0);
    drive(1'b1, 16'd303, 1'b0, 1'b0);
    chk("mrst.pre", count, 3);
    rst_n = 1'b0;
    drive(1'b1, 16'd400, 1'b1, 1'b1);
    rst_n = 1'b1;
    chk("mrst.count", count, 0);
    chk("mrst.valid", out_valid, 1'b0);
    drive(1'b0, 16'd0, 1'b0, 1'b0);
    chk("mrst.still_empty", empty, 1'b1);

    // wrap: step FFF0..0010 streamed through, pointers wrap twice
    for (int i = 0; i < 33; i++) begin
      s = 16'hFFF0 + 16'(i);
      drive(1'b1, s, 1'b1, 1'b0);
      chk_head($sformatf("wrap%0d", i), s);
      chk($sformatf("wrap%0d.count", i), count, 1);
    end
    drive(1'b0, 16'd0, 1'b1, 1'b0);
    chk("wrap.empty", empty, 1'b1);
    chk("wrap.drop", drop_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/prng_sample_fifo.md
PRNG_SAMPLE_FIFO -- requirements
Module: prng_sample_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of sample entries; SHALL be a power of two, at least 2.
REQ-002 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port clear  input  1  synchronous flush of FIFO contents and drop statistics.
REQ-005 Port in_valid  input  1  producer sample present this cycle.
REQ-006 Port in_x  input  8  PRNG x sample.
REQ-007 Port in_y  input  8  PRNG y sample.
REQ-008 Port in_step  input  16  PRNG step index for the sample.
REQ-009 Port out_valid  output  1  head entry available.
REQ-010 Port out_ready  input  1  consumer accepts head entry.
REQ-011 Port out_x / out_y / out_step  output  8 / 8 / 16  head entry fields.
REQ-012 Port count  output  $clog2(DEPTH)+1  current occupancy.
REQ-013 Port full / empty  output  1 / 1  occupancy flags.
REQ-014 Port drop_count  output  16  number of samples lost to overflow.
REQ-015 Port overflow  output  1  sticky flag: at least one sample dropped.

Function
REQ-016 The producer has no back-pressure; the block SHALL accept a push whenever in_valid=1 and the FIFO is not full or a pop occurs in the same cycle.
REQ-017 A pop SHALL occur exactly when out_valid=1 and out_ready=1.
REQ-018 A sample pushed in cycle N SHALL appear on out_* with out_valid=1 no earlier than cycle N+1; there is no write-through bypass.
REQ-019 out_valid SHALL equal !empty, and empty SHALL equal (count==0).
REQ-020 full SHALL equal (count==DEPTH).
REQ-021 out_x, out_y and out_step SHALL reflect the entry at the read pointer and SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 Entries SHALL leave the FIFO in push order, with fields kept together and unmodified.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH.
REQ-024 count SHALL change per cycle as follows:
- push and pop together: unchanged;
- push only: +1;
- pop only: -1.
REQ-025 At full with a simultaneous pop, the push SHALL be accepted and count SHALL remain DEPTH.
REQ-026 In_valid=1 while full with no pop SHALL be handled as a drop:
- the sample is discarded;
- storage is unchanged;
- drop_count increments;
- overflow is set.
REQ-027 drop_count SHALL saturate at 16'hFFFF.
REQ-028 overflow SHALL stay 1 until clear or reset.
REQ-029 Pop while empty SHALL be ignored; out_ready is a don't-care when out_valid=0.
REQ-030 clear=1 SHALL take priority over push, pop and drop in the same cycle. Next cycle:
- count=0;
- both pointers = 0;
- drop_count=0;
- overflow=0.
REQ-031 in_step SHALL be stored as given; step values of 16'hFFFF followed by 16'h0000 are ordinary data and SHALL receive no special handling.

Reset
REQ-032 When rst_n=0 at a rising clk edge, the next state SHALL be:
- count=0, empty=1, full=0, out_valid=0;
- both pointers = 0;
- drop_count=0, overflow=0.
REQ-033 rst_n SHALL take priority over clear and all traffic; a reset mid-stream SHALL discard every stored entry.
REQ-034 Storage array contents SHALL NOT require reset; out_x, out_y and out_step are don't-care while out_valid=0.

Structure
REQ-035 Shared package prng_pkg SHALL hold:
- constants X_W=8, Y_W=8, STEP_W=16, SAMPLE_W=32;
- packed typedef prng_sample_t {step, x, y}.
REQ-036 Sub-module prng_sample_mem (DEPTH x SAMPLE_W, 1 write port, 1 asynchronous read port, no reset) SHALL hold the storage.
REQ-037 Pointer, count and statistics logic SHALL reside in prng_sample_fifo.

Verification
REQ-038 Reset: hold rst_n=0 with in_valid=1 for 3 cycles -> count=0, empty=1, out_valid=0, drop_count=0, overflow=0.
REQ-039 Ordering: push steps 1..5 (x=step, y=2*step mod 256), out_ready=1 -> outputs step 1..5 in order; first out_valid appears one cycle after first push.
REQ-040 Overflow: out_ready=0, push 20 samples with DEPTH=16 -> full=1, count=16, drop_count=4, overflow=1; drain yields steps 1..16.
REQ-041 Full with simultaneous push/pop: fill to 16, then in_valid=1 and out_ready=1 for 10 cycles -> count stays 16, drop_count unchanged, order preserved.
REQ-042 Clear: 7 entries and drop_count=3, then clear=1 with in_valid=1 and out_ready=1 -> next cycle count=0, drop_count=0, overflow=0, pushed sample lost.
REQ-043 Wrap: continuous push/pop of steps 16'hFFF0..16'h0010 -> output sequence identical; pointers wrap with no gaps or duplicates.
